// File: rtl/vga_timing_generator_if.sv
// Raster timing bundle from the VGA timing generator to its consumer.
//   master : drives sync, blank, coordinates, strobes and frame count
//   slave  : samples them (VGA controller, which delays sync/blank to match pixel data)
interface vga_timing_generator_if;
    logic        out_h_sync;
    logic        out_v_sync;
    logic        out_blank_n;
    logic [10:0] out_pixel_x;
    logic [10:0] out_pixel_y;
    logic        out_line_start;
    logic        out_frame_start;
    logic [7:0]  out_frame_count;

    modport master (
        output out_h_sync, out_v_sync, out_blank_n, out_pixel_x, out_pixel_y,
               out_line_start, out_frame_start, out_frame_count
    );

    modport slave (
        input  out_h_sync, out_v_sync, out_blank_n, out_pixel_x, out_pixel_y,
               out_line_start, out_frame_start, out_frame_count
    );
endinterface

// File: rtl/vga_timing_generator.sv
// VGA raster timing generator. Free-running h/v counters walk the raster;
// every output is a registered decode of the counters, so outputs lag the
// counters by exactly one clock.
// Ports:
//   in_vga_clock : pixel clock, all logic on the rising edge
//   in_reset_n   : synchronous active-low reset
//   vga          : timing bundle (sync, blank_n, pixel x/y, line/frame strobes,
//                  frame counter); consumers use pixel x/y bits [9:0] gated by blank_n
module vga_timing_generator #(
    parameter int unsigned H_VISIBLE     = 640,
    parameter int unsigned H_FRONT       = 16,
    parameter int unsigned H_SYNC        = 96,
    parameter int unsigned H_BACK        = 48,
    parameter int unsigned V_VISIBLE     = 480,
    parameter int unsigned V_FRONT       = 10,
    parameter int unsigned V_SYNC        = 2,
    parameter int unsigned V_BACK        = 33,
    parameter bit          H_SYNC_ACTIVE = 1'b0,
    parameter bit          V_SYNC_ACTIVE = 1'b0
) (
    input  logic                    in_vga_clock,
    input  logic                    in_reset_n,
    vga_timing_generator_if.master  vga
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [10:0] H_LAST       = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST       = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS        = 11'(H_VISIBLE);
    localparam logic [10:0] V_VIS        = 11'(V_VISIBLE);
    localparam logic [10:0] H_SYNC_FIRST = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] H_SYNC_LAST  = 11'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [10:0] V_SYNC_FIRST = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] V_SYNC_LAST  = 11'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic [10:0] h_cnt;
    logic [10:0] v_cnt;
    // Set once the first frame after reset has been announced; the frame
    // counter only advances on frame starts after that one.
    logic        frame_seen;

    logic h_visible;
    logic v_visible;
    logic h_in_sync;
    logic v_in_sync;
    logic at_origin;

    always_comb begin
        h_visible = (h_cnt < H_VIS);
        v_visible = (v_cnt < V_VIS);
        h_in_sync = (h_cnt >= H_SYNC_FIRST) && (h_cnt <= H_SYNC_LAST);
        // Whole lines, including their horizontal blanking, so v_sync edges
        // line up with x = 0.
        v_in_sync = (v_cnt >= V_SYNC_FIRST) && (v_cnt <= V_SYNC_LAST);
        at_origin = (h_cnt == 11'd0) && (v_cnt == 11'd0);
    end

    always_ff @(posedge in_vga_clock) begin
        if (!in_reset_n) begin
            h_cnt               <= 11'd0;
            v_cnt               <= 11'd0;
            frame_seen          <= 1'b0;
            vga.out_h_sync      <= ~H_SYNC_ACTIVE;
            vga.out_v_sync      <= ~V_SYNC_ACTIVE;
            vga.out_blank_n     <= 1'b0;
            vga.out_pixel_x     <= 11'd0;
            vga.out_pixel_y     <= 11'd0;
            vga.out_line_start  <= 1'b0;
            vga.out_frame_start <= 1'b0;
            vga.out_frame_count <= 8'd0;
        end else begin
            if (h_cnt == H_LAST) begin
                h_cnt <= 11'd0;
                v_cnt <= (v_cnt == V_LAST) ? 11'd0 : v_cnt + 11'd1;
            end else begin
                h_cnt <= h_cnt + 11'd1;
            end

            vga.out_h_sync      <= h_in_sync ? H_SYNC_ACTIVE : ~H_SYNC_ACTIVE;
            vga.out_v_sync      <= v_in_sync ? V_SYNC_ACTIVE : ~V_SYNC_ACTIVE;
            vga.out_blank_n     <= h_visible && v_visible;
            vga.out_pixel_x     <= h_cnt;
            vga.out_pixel_y     <= v_cnt;
            vga.out_line_start  <= (h_cnt == 11'd0);
            vga.out_frame_start <= at_origin;

            if (at_origin) begin
                frame_seen <= 1'b1;
                if (frame_seen) begin
                    vga.out_frame_count <= vga.out_frame_count + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_generator.sv
module tb_vga_timing_generator;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        blank;
        logic [10:0] x;
        logic [10:0] y;
        logic        ls;
        logic        fs;
        logic [7:0]  fc;
    } vga_obs_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_d = 1'b0;   // default 640x480
    logic rst_h = 1'b0;   // 800x600, active-high syncs
    logic rst_s = 1'b0;   // tiny raster for frame-level checks

    vga_timing_generator_if vga_d ();
    vga_timing_generator_if vga_h ();
    vga_timing_generator_if vga_s ();

    vga_timing_generator dut_d (
        .in_vga_clock (clk),
        .in_reset_n   (rst_d),
        .vga          (vga_d)
    );

    vga_timing_generator #(
        .H_VISIBLE(800), .H_FRONT(40), .H_SYNC(128), .H_BACK(88),
        .V_VISIBLE(600), .V_FRONT(1),  .V_SYNC(4),   .V_BACK(23),
        .H_SYNC_ACTIVE(1'b1), .V_SYNC_ACTIVE(1'b1)
    ) dut_h (
        .in_vga_clock (clk),
        .in_reset_n   (rst_h),
        .vga          (vga_h)
    );

    localparam int S_HT = 18;
    localparam int S_VT = 11;

    vga_timing_generator #(
        .H_VISIBLE(10), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_VISIBLE(6),  .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
        .H_SYNC_ACTIVE(1'b1), .V_SYNC_ACTIVE(1'b0)
    ) dut_s (
        .in_vga_clock (clk),
        .in_reset_n   (rst_s),
        .vga          (vga_s)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_d = 0, n_h = 0, n_s = 0;      // edges since reset release, per instance
    int prev_ls = -1;
    int seen_fs = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Edge n after reset release shows raster index n-1 of an endless
    // sequence of frames; n == 0 means the last edge had reset asserted.
    function automatic vga_obs_t model(input int n, input int hv, input int hf, input int hsw,
                                       input int hb, input int vv, input int vf, input int vsw,
                                       input int vb, input bit hp, input bit vp);
        vga_obs_t e;
        int ht, vt, idx, h, v, fr;
        e = '0;
        e.hs = ~hp;
        e.vs = ~vp;
        if (n > 0) begin
            ht  = hv + hf + hsw + hb;
            vt  = vv + vf + vsw + vb;
            idx = (n - 1) % (ht * vt);
            fr  = (n - 1) / (ht * vt);
            h   = idx % ht;
            v   = idx / ht;
            e.blank = (h < hv) && (v < vv);
            e.hs    = (h >= hv + hf && h < hv + hf + hsw) ? hp : ~hp;
            e.vs    = (v >= vv + vf && v < vv + vf + vsw) ? vp : ~vp;
            e.x     = 11'(h);
            e.y     = 11'(v);
            e.ls    = (h == 0);
            e.fs    = (h == 0) && (v == 0);
            e.fc    = 8'(fr);
        end
        return e;
    endfunction

    task automatic cmp(input string nm, input vga_obs_t o, input vga_obs_t e);
        check({nm, ".h_sync"},      o.hs,    e.hs);
        check({nm, ".v_sync"},      o.vs,    e.vs);
        check({nm, ".blank_n"},     o.blank, e.blank);
        check({nm, ".pixel_x"},     o.x,     e.x);
        check({nm, ".pixel_y"},     o.y,     e.y);
        check({nm, ".line_start"},  o.ls,    e.ls);
        check({nm, ".frame_start"}, o.fs,    e.fs);
        check({nm, ".frame_count"}, o.fc,    e.fc);
    endtask

    task automatic step();
        vga_obs_t od, oh, os;
        @(posedge clk);
        n_d = rst_d ? n_d + 1 : 0;
        n_h = rst_h ? n_h + 1 : 0;
        n_s = rst_s ? n_s + 1 : 0;
        @(negedge clk);
        od = {vga_d.out_h_sync, vga_d.out_v_sync, vga_d.out_blank_n, vga_d.out_pixel_x,
              vga_d.out_pixel_y, vga_d.out_line_start, vga_d.out_frame_start, vga_d.out_frame_count};
        oh = {vga_h.out_h_sync, vga_h.out_v_sync, vga_h.out_blank_n, vga_h.out_pixel_x,
              vga_h.out_pixel_y, vga_h.out_line_start, vga_h.out_frame_start, vga_h.out_frame_count};
        os = {vga_s.out_h_sync, vga_s.out_v_sync, vga_s.out_blank_n, vga_s.out_pixel_x,
              vga_s.out_pixel_y, vga_s.out_line_start, vga_s.out_frame_start, vga_s.out_frame_count};

        cmp("d", od, model(n_d, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0));
        cmp("h", oh, model(n_h, 800, 40, 128, 88, 600, 1, 4, 23, 1'b1, 1'b1));
        cmp("s", os, model(n_s, 10, 2, 3, 3, 6, 1, 2, 2, 1'b1, 1'b0));

        // Literal spot checks at the timing boundaries.
        if (n_d == 1) begin
            check("d_first_blank", od.blank, 1);
            check("d_first_ls",    od.ls,    1);
            check("d_first_fs",    od.fs,    1);
            check("d_first_fc",    od.fc,    0);
            check("d_first_hs",    od.hs,    1);
            check("d_first_vs",    od.vs,    1);
        end
        if (n_d == 640) check("d_x639",        od.x,     639);
        if (n_d == 641) check("d_blank_x640",  od.blank, 0);
        if (n_d == 656) check("d_hs_x655",     od.hs,    1);
        if (n_d == 657) check("d_hs_x656",     od.hs,    0);
        if (n_d == 752) check("d_hs_x751",     od.hs,    0);
        if (n_d == 753) check("d_hs_x752",     od.hs,    1);
        if (n_d == 801) check("d_line1_ls",    od.ls,    1);
        if (n_h == 1056) check("h_x1055",      oh.x,     1055);
        if (n_h == 1057) check("h_x_wrap",     oh.x,     0);
        if (n_h == 840) check("h_hs_x839",     oh.hs,    0);
        if (n_h == 841) check("h_hs_x840",     oh.hs,    1);
        if (n_h == 968) check("h_hs_x967",     oh.hs,    1);
        if (n_h == 969) check("h_hs_x968",     oh.hs,    0);

        // Small raster: line period and frame counter sequence from observed pulses.
        if (!rst_s) begin
            prev_ls = -1;
            seen_fs = 0;
        end else begin
            if (os.ls) begin
                if (prev_ls >= 0) check("s_line_period", n_s - prev_ls, S_HT);
                prev_ls = n_s;
            end
            if (os.fs) begin
                check("s_frame_count_seq", os.fc, seen_fs % 256);
                seen_fs++;
            end
        end
    endtask

    initial begin
        int guard;
        repeat (3) step();
        rst_d = 1'b1;
        rst_h = 1'b1;
        rst_s = 1'b1;

        // 257 small frames plus a little of the 258th.
        repeat (257 * S_HT * S_VT + 10) step();
        check("s_frames_seen", seen_fs, 258);

        // One-cycle reset at position (7,4) of the small raster.
        guard = 0;
        while (((n_s - 1) % (S_HT * S_VT)) != 4 * S_HT + 7 && guard < 400) begin
            step();
            guard++;
        end
        check("s_wait_pos", (guard < 400), 1);
        rst_s = 1'b0;
        step();
        check("s_rst_blank", vga_s.out_blank_n,     0);
        check("s_rst_fc",    vga_s.out_frame_count, 0);
        rst_s = 1'b1;
        step();
        check("s_rel_fs",    vga_s.out_frame_start, 1);
        check("s_rel_x",     vga_s.out_pixel_x,     0);

        // Randomly placed reset pulses of random length.
        repeat (6) begin
            repeat ($urandom_range(20, 500)) step();
            rst_s = 1'b0;
            repeat ($urandom_range(1, 3)) step();
            rst_s = 1'b1;
        end
        repeat (300) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
